ps2_mouse_tx: RTL and testbench
===============================

PS2_MOUSE_TX -- requirements
Module: ps2_mouse_tx

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 2000, meaning clk cycles per PS/2 clock half-period; legal range 4..65535.
REQ-002 SHALL have parameter GAP_HALVES, default 4, meaning idle half-periods between bytes and between packets.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ps2_mouse, input, 25 bits: [24] toggles once per event; [7:0] status byte; [15:8] X delta; [23:16] Y delta.
REQ-006 SHALL have port ps2_clk_in, input, 1 bit: PS/2 clock line state, asynchronous to clk.
REQ-007 SHALL have port ps2_clk_out, output, 1 bit: open-drain clock drive; 0 = pull low, 1 = release.
REQ-008 SHALL have port ps2_data_out, output, 1 bit: open-drain data drive; 0 = pull low, 1 = release.
REQ-009 SHALL have port busy, output, 1 bit: high while a packet is pending or in transmission.
REQ-010 SHALL have port overflow, output, 1 bit: one-cycle pulse when a pending packet is overwritten.

Function
REQ-011 SHALL synchronise ps2_clk_in through two flops; all host-inhibit decisions SHALL use the synchronised value (clk_s).
REQ-012 SHALL register ps2_mouse[24] every cycle; an event is a difference between the registered and current toggle.
REQ-013 SHALL treat the first cycle after reset deassertion as arming only: load the toggle register, generate no event.
REQ-014 On an event, SHALL capture the three bytes into a one-packet pending slot.
REQ-015 If the pending slot is already full, SHALL overwrite it and pulse overflow for exactly one cycle.
REQ-016 SHALL move pending to the active packet, freeing the slot, when the FSM is in IDLE; the packet leaves IDLE on the next cycle.
REQ-017 SHALL have FSM states IDLE, INHIBIT, HIGH, LOW and GAP.
REQ-018 From IDLE with a packet: go to INHIBIT if clk_s = 0, else to HIGH with bit index 0 of byte 0.
REQ-019 INHIBIT: both lines released; go to HIGH with bit 0 when clk_s = 1.
REQ-020 HIGH: ps2_data_out = current frame bit, ps2_clk_out = 1 for HALF_PERIOD cycles, then go to LOW.
REQ-021 LOW: ps2_clk_out = 0, data held, for HALF_PERIOD cycles, then go back to HIGH with the next bit.
REQ-022 Frame order SHALL be: start 0, data bits LSB first, odd parity, stop 1 -- 11 bits, 11 clock-low pulses per byte.
REQ-023 After the stop bit's LOW phase SHALL enter GAP: both lines released for GAP_HALVES*HALF_PERIOD cycles.
REQ-024 After GAP, SHALL send the next byte (status, X, Y order) via the REQ-018 check, or return to IDLE after Y.
REQ-025 On the last cycle of each HIGH phase before the parity bit, if clk_s = 0, SHALL abort the frame.
REQ-026 On abort, SHALL release both lines next cycle, enter INHIBIT, and retransmit the active packet from byte 0.
REQ-027 A newer pending packet SHALL NOT pre-empt the active packet; it is sent after the active packet.
REQ-028 busy SHALL equal (FSM != IDLE) OR pending-slot-full.
REQ-029 The bit-period counter SHALL be 16 bits and reload at every state change; no cumulative drift is allowed.

Reset
REQ-030 While reset is high, outputs SHALL be: ps2_clk_out = 1, ps2_data_out = 1, busy = 0, overflow = 0.
REQ-031 Reset SHALL force the FSM to IDLE, clear the pending and active packets, and clear the arm flag, taking effect immediately including mid-frame.

Verification (HALF_PERIOD = 4, GAP_HALVES = 4)
REQ-032 Send bytes 08/05/FB -> exactly 33 ps2_clk_out low pulses; host-side decode gives 08 with parity 0, 05 with parity 1, FB with parity 0; each low pulse is 4 cycles; inter-byte gap is 16 cycles; busy drops after the Y stop bit's LOW phase.
REQ-033 Second toggle during byte 1 -> overflow stays 0; second packet starts after the first packet's gap; busy stays high throughout.
REQ-034 Two further toggles during transmission -> overflow pulses once (1 cycle); only the last packet is transmitted after the active one.
REQ-035 Hold ps2_clk_in low before the event -> no ps2_clk_out low pulse while held; release -> transmission begins within 4 cycles with a start bit.
REQ-036 Pull ps2_clk_in low during data bit 3 of byte 1 -> lines released in 1 cycle; after release, retransmission starts at byte 0 (status byte).
REQ-037 Assert reset mid-LOW phase -> ps2_clk_out = 1 and ps2_data_out = 1 the same cycle; ps2_mouse[24] = 1 at reset release produces no packet.

Source files
------------

// File: rtl/ps2_mouse_tx.sv
// PS/2 mouse device-side transmitter: turns toggle-qualified 3-byte mouse events
// into 11-bit PS/2 frames (status, X, Y), yielding to host clock inhibit.
module ps2_mouse_tx #(
  parameter int unsigned HALF_PERIOD = 2000,
  parameter int unsigned GAP_HALVES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic        ps2_clk_in,
  output logic        ps2_clk_out,
  output logic        ps2_data_out,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_HIGH    = 3'd2,
    S_LOW     = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam logic [15:0] HALF_LOAD  = 16'(HALF_PERIOD - 32'd1);
  localparam logic [15:0] GAP_LOAD   = 16'(GAP_HALVES * HALF_PERIOD - 32'd1);
  localparam logic [3:0]  BIT_PARITY = 4'd9;
  localparam logic [3:0]  BIT_STOP   = 4'd10;
  localparam logic [1:0]  BYTE_LAST  = 2'd2;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic logic [7:0] pkt_byte(input logic [23:0] p, input logic [1:0] idx);
    logic [7:0] v;
    case (idx)
      2'd0:    v = p[7:0];
      2'd1:    v = p[15:8];
      2'd2:    v = p[23:16];
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Bit 0 is the start bit, 1..8 carry data LSB first, then parity and stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic v;
    case (idx)
      4'd0:    v = 1'b0;
      4'd9:    v = odd_parity(b);
      4'd10:   v = 1'b1;
      default: v = ((idx >= 4'd1) && (idx <= 4'd8)) ? b[3'(idx - 4'd1)] : 1'b1;
    endcase
    return v;
  endfunction

  logic        r_clk_meta;
  logic        r_clk_s;
  logic        r_tog;
  logic        r_armed;
  logic [23:0] r_pend;
  logic        r_pend_full;
  logic [23:0] r_active;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [3:0]  r_bit;
  logic [3:0]  w_bit_nxt;
  logic [1:0]  r_byte;
  logic [1:0]  w_byte_nxt;
  logic        r_clk_out;
  logic        r_data_out;
  logic        r_busy;
  logic        r_overflow;

  logic        w_event;
  logic        w_take;
  logic        w_overwrite;
  logic        w_pend_full_nxt;
  logic        w_cnt_done;
  logic [23:0] w_pkt_src;
  logic        w_clk_out_nxt;
  logic        w_data_out_nxt;

  // The idle bus level is high, so the synchroniser resets to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_meta <= 1'b1;
      r_clk_s    <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk_in;
      r_clk_s    <= r_clk_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tog   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_tog   <= ps2_mouse[24];
      r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_event         = r_armed & (ps2_mouse[24] ^ r_tog);
    w_take          = (r_state == S_IDLE) & r_pend_full;
    w_overwrite     = w_event & r_pend_full & ~w_take;
    w_pend_full_nxt = w_event | (r_pend_full & ~w_take);
    w_pkt_src       = w_take ? r_pend : r_active;
    w_cnt_done      = (r_cnt == 16'd0);
  end

  // A new event may land in the slot on the same cycle the old one is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend      <= 24'd0;
      r_pend_full <= 1'b0;
      r_active    <= 24'd0;
    end else begin
      if (w_event) begin
        r_pend <= ps2_mouse[23:0];
      end
      r_pend_full <= w_pend_full_nxt;
      if (w_take) begin
        r_active <= r_pend;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 4'd0;
      r_byte  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_byte_nxt = 2'd0;
          w_bit_nxt  = 4'd0;
          if (r_clk_s) begin
            w_state_nxt = S_HIGH;
          end else begin
            w_state_nxt = S_INHIBIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_INHIBIT: begin
        if (r_clk_s) begin
          w_state_nxt = S_HIGH;
          w_bit_nxt   = 4'd0;
        end else begin
          w_state_nxt = S_INHIBIT;
        end
      end
      S_HIGH: begin
        // Host may only abort up to the last data bit; the whole packet restarts.
        if (w_cnt_done) begin
          if (!r_clk_s && (r_bit < BIT_PARITY)) begin
            w_state_nxt = S_INHIBIT;
            w_byte_nxt  = 2'd0;
            w_bit_nxt   = 4'd0;
          end else begin
            w_state_nxt = S_LOW;
          end
        end else begin
          w_state_nxt = S_HIGH;
        end
      end
      S_LOW: begin
        if (w_cnt_done) begin
          if (r_bit == BIT_STOP) begin
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_HIGH;
            w_bit_nxt   = r_bit + 4'd1;
          end
        end else begin
          w_state_nxt = S_LOW;
        end
      end
      S_GAP: begin
        if (w_cnt_done) begin
          if (r_byte == BYTE_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_byte_nxt = r_byte + 2'd1;
            w_bit_nxt  = 4'd0;
            if (r_clk_s) begin
              w_state_nxt = S_HIGH;
            end else begin
              w_state_nxt = S_INHIBIT;
            end
          end
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_bit_nxt   = 4'd0;
        w_byte_nxt  = 2'd0;
      end
    endcase
    // Reloading on every state change keeps each phase exact, with no drift.
    if (w_state_nxt != r_state) begin
      if (w_state_nxt == S_GAP) begin
        w_cnt_nxt = GAP_LOAD;
      end else begin
        w_cnt_nxt = HALF_LOAD;
      end
    end else if (w_cnt_done) begin
      w_cnt_nxt = 16'd0;
    end else begin
      w_cnt_nxt = r_cnt - 16'd1;
    end
  end

  // Line levels are derived from the next state so the registered pins line up with it.
  always_comb begin
    w_clk_out_nxt  = 1'b1;
    w_data_out_nxt = 1'b1;
    case (w_state_nxt)
      S_HIGH: begin
        w_clk_out_nxt  = 1'b1;
        w_data_out_nxt = frame_bit(pkt_byte(w_pkt_src, w_byte_nxt), w_bit_nxt);
      end
      S_LOW: begin
        w_clk_out_nxt  = 1'b0;
        w_data_out_nxt = frame_bit(pkt_byte(w_pkt_src, w_byte_nxt), w_bit_nxt);
      end
      default: begin
        w_clk_out_nxt  = 1'b1;
        w_data_out_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_out  <= 1'b1;
      r_data_out <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_clk_out  <= w_clk_out_nxt;
      r_data_out <= w_data_out_nxt;
      r_busy     <= (w_state_nxt != S_IDLE) | w_pend_full_nxt;
      r_overflow <= w_overwrite;
    end
  end

  assign ps2_clk_out  = r_clk_out;
  assign ps2_data_out = r_data_out;
  assign busy         = r_busy;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_ps2_mouse_tx.sv
// Directed bench for ps2_mouse_tx: a host-side monitor decodes frames, pulse
// widths and gaps; a vector table plus hand sequences cover the corner cases.
module tb_ps2_mouse_tx;
  localparam int HP = 4;
  localparam int GH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic        ps2_clk_in;
  logic        ps2_clk_out;
  logic        ps2_data_out;
  logic        busy;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_mouse_tx #(.HALF_PERIOD(HP), .GAP_HALVES(GH)) dut (
    .clk(clk), .reset(reset), .ps2_mouse(ps2_mouse), .ps2_clk_in(ps2_clk_in),
    .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] st;
    logic [7:0] dx;
    logic [7:0] dy;
    logic       pst;
    logic       pdx;
    logic       pdy;
  } vec_t;
  vec_t vecs [3];

  int   cyc = 0;
  int   nbits = 0;
  logic bits [0:4095];
  int   gaps [0:255];
  int   ngaps = 0;
  int   run = 0;
  logic in_run = 1'b0;
  int   low_len = 0;
  int   bad_len = 0;
  int   novf = 0;
  int   ovf_wide = 0;
  int   last_rise = 0;
  int   busy_fall = 0;
  int   nbusy_fall = 0;
  logic prev_clk = 1'b1;
  logic prev_data = 1'b1;
  logic prev_busy = 1'b0;
  logic prev_ovf = 1'b0;

  // Host-side view of the bus: samples data on each clock fall, times pulses and gaps.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_clk  <= ps2_clk_out;
    prev_data <= ps2_data_out;
    prev_busy <= busy;
    prev_ovf  <= overflow;
    if (!ps2_clk_out && prev_clk) begin
      bits[nbits] <= ps2_data_out;
      nbits       <= nbits + 1;
      low_len     <= 1;
    end else if (!ps2_clk_out) begin
      low_len <= low_len + 1;
    end
    if (ps2_clk_out && !prev_clk) begin
      last_rise <= cyc;
      run       <= 1;
      in_run    <= 1'b1;
      if (low_len != HP) bad_len <= bad_len + 1;
    end else if (!ps2_clk_out) begin
      in_run <= 1'b0;
    end else if (in_run) begin
      if (ps2_data_out) begin
        run <= run + 1;
      end else begin
        if (prev_data) begin
          gaps[ngaps] <= run;
          ngaps       <= ngaps + 1;
        end
        in_run <= 1'b0;
      end
    end
    if (overflow) novf <= novf + 1;
    if (overflow && prev_ovf) ovf_wide <= ovf_wide + 1;
    if (prev_busy && !busy) begin
      busy_fall  <= cyc;
      nbusy_fall <= nbusy_fall + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    ps2_mouse = {~ps2_mouse[24], y, x, s};
  endtask

  task automatic wait_bits(input int target, input int budget, input string name);
    int k = 0;
    while (nbits < target && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(nbits >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  function automatic logic opar(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic check_pkt(input string tag, input int rd, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2,
                           input logic q0, input logic q1, input logic q2);
    logic [7:0]  bb [3];
    logic        qq [3];
    logic [10:0] rx;
    logic [10:0] ex;
    bb[0] = b0; bb[1] = b1; bb[2] = b2;
    qq[0] = q0; qq[1] = q1; qq[2] = q2;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 11; i++) rx[i] = bits[rd + b * 11 + i];
      ex = {1'b1, qq[b], bb[b], 1'b0};
      check($sformatf("%s_frame%0d", tag, b), 32'(rx), 32'(ex));
    end
  endtask

  initial begin
    int p0;
    int o0;
    int f0;
    int k;
    vecs[0] = '{8'h08, 8'h05, 8'hFB, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 8'h3C, 8'h01, 1'b1, 1'b1, 1'b0};

    reset = 1'b0;
    ps2_mouse = 25'd0;
    ps2_clk_in = 1'b1;
    #1 reset = 1'b1;
    tick(3);
    check("reset_outputs", 32'({ps2_clk_out, ps2_data_out, busy, overflow}), 32'hC);
    reset = 1'b0;
    tick(5);
    check("idle_after_reset", 32'({ps2_clk_out, ps2_data_out, busy}), 32'h6);

    for (int v = 0; v < 3; v++) begin
      p0 = nbits; o0 = novf; f0 = nbusy_fall;
      send(vecs[v].st, vecs[v].dx, vecs[v].dy);
      tick(2);
      check($sformatf("v%0d_busy_rise", v), 32'(busy), 32'd1);
      wait_idle(1200, $sformatf("v%0d_done", v));
      tick(2);
      check($sformatf("v%0d_pulses", v), 32'(nbits - p0), 32'd33);
      check_pkt($sformatf("v%0d", v), p0, vecs[v].st, vecs[v].dx, vecs[v].dy,
                vecs[v].pst, vecs[v].pdx, vecs[v].pdy);
      check($sformatf("v%0d_gap1", v), 32'(gaps[ngaps - 2]), 32'd16);
      check($sformatf("v%0d_gap2", v), 32'(gaps[ngaps - 1]), 32'd16);
      check($sformatf("v%0d_busy_tail", v), 32'(busy_fall - last_rise), 32'd16);
      check($sformatf("v%0d_busy_falls", v), 32'(nbusy_fall - f0), 32'd1);
      check($sformatf("v%0d_no_ovf", v), 32'(novf - o0), 32'd0);
    end

    // Second packet queued behind the first: no overflow, busy never drops.
    p0 = nbits; o0 = novf; f0 = nbusy_fall;
    send(8'h09, 8'h12, 8'h34);
    wait_bits(p0 + 5, 300, "q_wait_b0");
    send(8'h28, 8'hFE, 8'h7F);
    wait_bits(p0 + 33, 600, "q_wait_pkt1");
    tick(1);
    check("q_busy_between", 32'(busy), 32'd1);
    wait_idle(1500, "q_done");
    tick(2);
    check("q_pulses", 32'(nbits - p0), 32'd66);
    check("q_no_ovf", 32'(novf - o0), 32'd0);
    check("q_busy_falls", 32'(nbusy_fall - f0), 32'd1);
    check("q_inter_packet_gap", 32'(gaps[ngaps - 3]), 32'd17);
    check_pkt("q_p1", p0, 8'h09, 8'h12, 8'h34, opar(8'h09), opar(8'h12), opar(8'h34));
    check_pkt("q_p2", p0 + 33, 8'h28, 8'hFE, 8'h7F, opar(8'h28), opar(8'hFE), opar(8'h7F));

    // Two toggles while active: the second overwrites the slot.
    p0 = nbits; o0 = novf;
    send(8'h01, 8'h02, 8'h03);
    wait_bits(p0 + 3, 300, "o_wait");
    send(8'h44, 8'h55, 8'h66);
    tick(20);
    send(8'h0F, 8'hF0, 8'h99);
    tick(3);
    check("o_ovf_once", 32'(novf - o0), 32'd1);
    wait_idle(1500, "o_done");
    tick(2);
    check("o_ovf_width", 32'(ovf_wide), 32'd0);
    check("o_pulses", 32'(nbits - p0), 32'd66);
    check_pkt("o_p1", p0, 8'h01, 8'h02, 8'h03, opar(8'h01), opar(8'h02), opar(8'h03));
    check_pkt("o_p2", p0 + 33, 8'h0F, 8'hF0, 8'h99, opar(8'h0F), opar(8'hF0), opar(8'h99));

    // Host holds the clock low before the event.
    ps2_clk_in = 1'b0;
    tick(4);
    p0 = nbits;
    send(8'h18, 8'h2A, 8'hD0);
    tick(40);
    check("h_no_pulse", 32'(nbits - p0), 32'd0);
    check("h_lines_released", 32'({busy, ps2_clk_out, ps2_data_out}), 32'h7);
    ps2_clk_in = 1'b1;
    k = 0;
    while (ps2_data_out !== 1'b0 && k < 10) begin
      tick(1);
      k++;
    end
    check("h_start_latency", 32'(k <= 4), 32'd1);
    wait_idle(1200, "h_done");
    tick(2);
    check("h_pulses", 32'(nbits - p0), 32'd33);
    check_pkt("h", p0, 8'h18, 8'h2A, 8'hD0, opar(8'h18), opar(8'h2A), opar(8'hD0));

    // Host pulls the clock low during data bit 3 of the status byte.
    p0 = nbits;
    send(8'hC3, 8'h11, 8'h22);
    wait_bits(p0 + 4, 300, "a_wait");
    ps2_clk_in = 1'b0;
    tick(6);
    check("a_last_high", 32'({ps2_clk_out, ps2_data_out}), 32'h2);
    tick(1);
    check("a_release", 32'({ps2_clk_out, ps2_data_out}), 32'h3);
    tick(20);
    check("a_no_pulse", 32'(nbits - p0), 32'd4);
    check("a_busy", 32'(busy), 32'd1);
    ps2_clk_in = 1'b1;
    wait_idle(1200, "a_done");
    tick(2);
    check("a_pulses", 32'(nbits - p0), 32'd37);
    check_pkt("a", p0 + 4, 8'hC3, 8'h11, 8'h22, opar(8'hC3), opar(8'h11), opar(8'h22));
    check("pulse_width", 32'(bad_len), 32'd0);

    // Reset in the middle of a LOW phase, toggle high at release.
    p0 = nbits;
    send(8'h77, 8'h66, 8'h55);
    wait_bits(p0 + 2, 300, "r_wait");
    check("r_in_low", 32'(ps2_clk_out), 32'd0);
    #1;
    reset = 1'b1;
    ps2_mouse = {1'b1, ps2_mouse[23:0]};
    #1;
    check("r_mid_low", 32'({ps2_clk_out, ps2_data_out, busy, overflow}), 32'hC);
    tick(3);
    reset = 1'b0;
    tick(60);
    check("r_no_packet", 32'(nbits - p0), 32'd2);
    check("r_not_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
